// File: rtl/mm_stream_host_if.sv
// Streaming bus between the host driver (master) and the matrix-multiply engine (slave).
// Carries operand elements with row/matrix framing one way and result elements back.
interface mm_stream_host_if #(
   parameter int unsigned DW = 8,
   parameter int unsigned OW = 20
);
   logic [DW-1:0] in_data;
   logic          col_end;
   logic          row_end;
   logic          busy;
   logic          valid;
   logic [OW-1:0] out_data;
   logic          change_row;
   logic          is_legal;

   modport master (
      output in_data, col_end, row_end,
      input  busy, valid, out_data, change_row, is_legal
   );

   modport slave (
      input  in_data, col_end, row_end,
      output busy, valid, out_data, change_row, is_legal
   );
endinterface

// File: rtl/mm_stream_host.sv
// Host-side driver for the matrix-multiply engine: streams two stored operand matrices and
// collects the result matrix into a readback buffer. Optional idle timeout: MM_STREAM_HOST_TIMEOUT_EN.
module mm_stream_host #(
   parameter int unsigned DW      = 8,
   parameter int unsigned OW      = 20,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic          cfg_sel,
   input  logic [1:0]    cfg_row,
   input  logic [1:0]    cfg_col,
   input  logic [DW-1:0] cfg_data,
   input  logic [3:0]    dim1,
   input  logic [3:0]    dim2,
   input  logic          start,
   mm_stream_host_if.master bus,
   input  logic [3:0]    res_addr,
   output logic [OW-1:0] res_data,
   output logic [1:0]    res_rows,
   output logic [1:0]    res_cols,
   output logic          legal,
   output logic          done,
   output logic          active
`ifdef MM_STREAM_HOST_TIMEOUT_EN
   ,
   output logic          timeout
`endif
);

   localparam int unsigned DIM    = 4;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_SEND1,
      S_SEND2,
      S_COLLECT,
      S_DONE
   } state_t;

   state_t state;

   logic [DW-1:0] mat1 [DIM][DIM];
   logic [DW-1:0] mat2 [DIM][DIM];
   logic [OW-1:0] res_buf [DEPTH];

   // Dimensions are held as (count - 1), latched when start is accepted.
   logic [1:0] rows1, cols1, rows2, cols2;
   logic [1:0] row, col;

   logic [DW-1:0] in_data_q;
   logic          col_end_q;
   logic          row_end_q;

   logic [3:0]       wr_ptr;
   logic [CNT_W-1:0] row_cnt;
   logic [CNT_W-1:0] col_cnt;
   logic             cols_fixed;
   logic             seen_valid;

`ifdef MM_STREAM_HOST_TIMEOUT_EN
   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   logic [TMO_W-1:0] tmo_cnt;
`endif

   if (TIMEOUT == 0) begin : g_bad_timeout
      $error("mm_stream_host: TIMEOUT must be nonzero");
   end

   assign bus.in_data = in_data_q;
   assign bus.col_end = col_end_q;
   assign bus.row_end = row_end_q;
   assign res_data    = res_buf[res_addr];

   // Walk of the matrix currently being streamed.
   logic [1:0]       cur_rows_c, cur_cols_c;
   logic             last_col_c, last_elem_c;
   logic [1:0]       row_nxt_c, col_nxt_c;
   logic [DW-1:0]    nxt_elem_c;
   logic             nxt_ce_c, nxt_re_c;
   logic [CNT_W-1:0] row_cnt_inc_c;
   logic             rows_done_c;
   logic [3:0]       wr_ptr_nxt_c;
   logic [1:0]       cols_sat_c;
   logic             buf_we_c;

   always_comb begin
      cur_rows_c    = (state == S_SEND2) ? rows2 : rows1;
      cur_cols_c    = (state == S_SEND2) ? cols2 : cols1;
      last_col_c    = (col == cur_cols_c);
      last_elem_c   = last_col_c && (row == cur_rows_c);
      col_nxt_c     = last_col_c ? 2'd0 : col + 2'd1;
      row_nxt_c     = last_col_c ? row + 2'd1 : row;
      nxt_elem_c    = (state == S_SEND2) ? mat2[row_nxt_c][col_nxt_c]
                                         : mat1[row_nxt_c][col_nxt_c];
      nxt_ce_c      = (col_nxt_c == cur_cols_c);
      nxt_re_c      = nxt_ce_c && (row_nxt_c == cur_rows_c);

      row_cnt_inc_c = row_cnt + CNT_W'(1);
      rows_done_c   = (row_cnt_inc_c == (CNT_W'(rows1) + CNT_W'(1)));
      cols_sat_c    = (col_cnt > CNT_W'(3)) ? 2'd3 : col_cnt[1:0];

      // A row change moves the write pointer to the start of the next 4-wide buffer row.
      if (bus.change_row)
         wr_ptr_nxt_c = (row_cnt_inc_c >= CNT_W'(DIM)) ? 4'd15 : {row_cnt_inc_c[1:0], 2'b00};
      else
         wr_ptr_nxt_c = (wr_ptr == 4'd15) ? 4'd15 : wr_ptr + 4'd1;

      buf_we_c = (state == S_COLLECT) && bus.valid && bus.is_legal;
   end

   // Operand storage, writable only while idle.
   always_ff @(posedge clk) begin
      if (cfg_we && (state == S_IDLE)) begin
         if (cfg_sel)
            mat2[cfg_row][cfg_col] <= cfg_data;
         else
            mat1[cfg_row][cfg_col] <= cfg_data;
      end
   end

   always_ff @(posedge clk) begin
      if (buf_we_c)
         res_buf[wr_ptr] <= bus.out_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         rows1      <= '0;
         cols1      <= '0;
         rows2      <= '0;
         cols2      <= '0;
         row        <= '0;
         col        <= '0;
         in_data_q  <= '0;
         col_end_q  <= 1'b0;
         row_end_q  <= 1'b0;
         wr_ptr     <= '0;
         row_cnt    <= '0;
         col_cnt    <= '0;
         cols_fixed <= 1'b0;
         seen_valid <= 1'b0;
         res_rows   <= '0;
         res_cols   <= '0;
         legal      <= 1'b0;
         done       <= 1'b0;
         active     <= 1'b0;
`ifdef MM_STREAM_HOST_TIMEOUT_EN
         tmo_cnt    <= '0;
         timeout    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state      <= S_WAIT;
                  active     <= 1'b1;
                  rows1      <= dim1[3:2];
                  cols1      <= dim1[1:0];
                  rows2      <= dim2[3:2];
                  cols2      <= dim2[1:0];
                  wr_ptr     <= '0;
                  row_cnt    <= '0;
                  col_cnt    <= '0;
                  cols_fixed <= 1'b0;
                  seen_valid <= 1'b0;
                  res_rows   <= '0;
                  res_cols   <= '0;
                  legal      <= 1'b0;
`ifdef MM_STREAM_HOST_TIMEOUT_EN
                  timeout    <= 1'b0;
`endif
               end
            end

            S_WAIT: begin
               if (!bus.busy) begin
                  state     <= S_SEND1;
                  row       <= '0;
                  col       <= '0;
                  in_data_q <= mat1[0][0];
                  col_end_q <= (cols1 == 2'd0);
                  row_end_q <= (cols1 == 2'd0) && (rows1 == 2'd0);
               end
            end

            S_SEND1: begin
               row <= last_elem_c ? 2'd0 : row_nxt_c;
               col <= last_elem_c ? 2'd0 : col_nxt_c;
               if (last_elem_c) begin
                  state     <= S_SEND2;
                  in_data_q <= mat2[0][0];
                  col_end_q <= (cols2 == 2'd0);
                  row_end_q <= (cols2 == 2'd0) && (rows2 == 2'd0);
               end else begin
                  in_data_q <= nxt_elem_c;
                  col_end_q <= nxt_ce_c;
                  row_end_q <= nxt_re_c;
               end
            end

            S_SEND2: begin
               if (last_elem_c) begin
                  state     <= S_COLLECT;
                  col_end_q <= 1'b0;
                  row_end_q <= 1'b0;
`ifdef MM_STREAM_HOST_TIMEOUT_EN
                  tmo_cnt   <= '0;
`endif
               end else begin
                  row       <= row_nxt_c;
                  col       <= col_nxt_c;
                  in_data_q <= nxt_elem_c;
                  col_end_q <= nxt_ce_c;
                  row_end_q <= nxt_re_c;
               end
            end

            S_COLLECT: begin
               if (bus.valid) begin
`ifdef MM_STREAM_HOST_TIMEOUT_EN
                  tmo_cnt    <= '0;
`endif
                  seen_valid <= 1'b1;
                  if (!seen_valid)
                     legal <= bus.is_legal;
                  if (!bus.is_legal) begin
                     // Engine rejected the operand shapes: report an empty, illegal result.
                     legal    <= 1'b0;
                     res_rows <= '0;
                     res_cols <= '0;
                     done     <= 1'b1;
                     active   <= 1'b0;
                     state    <= S_DONE;
                  end else begin
                     wr_ptr <= wr_ptr_nxt_c;
                     if (bus.change_row) begin
                        row_cnt  <= row_cnt_inc_c;
                        res_rows <= row_cnt[1:0];
                        if (!cols_fixed) begin
                           res_cols   <= cols_sat_c;
                           cols_fixed <= 1'b1;
                        end
                        if (rows_done_c) begin
                           done   <= 1'b1;
                           active <= 1'b0;
                           state  <= S_DONE;
                        end
                     end else if (!cols_fixed && (col_cnt != CNT_W'(7))) begin
                        col_cnt <= col_cnt + CNT_W'(1);
                     end
                  end
               end else begin
`ifdef MM_STREAM_HOST_TIMEOUT_EN
                  if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                     legal   <= 1'b0;
                     timeout <= 1'b1;
                     done    <= 1'b1;
                     active  <= 1'b0;
                     state   <= S_DONE;
                  end else begin
                     tmo_cnt <= tmo_cnt + TMO_W'(1);
                  end
`endif
               end
            end

            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end

            default: begin
               state  <= S_IDLE;
               done   <= 1'b0;
               active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mm_stream_host.sv
// Directed self-checking bench for mm_stream_host: framing, busy wait, illegal result,
// 1x1 operands, mid-transaction reset and (with MM_STREAM_HOST_TIMEOUT_EN) the idle timeout.
module tb_mm_stream_host;
   localparam int unsigned DW      = 8;
   localparam int unsigned OW      = 20;
   localparam int unsigned TIMEOUT = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_we, cfg_sel;
   logic [1:0]    cfg_row, cfg_col;
   logic [DW-1:0] cfg_data;
   logic [3:0]    dim1, dim2;
   logic          start;
   logic [3:0]    res_addr;
   logic [OW-1:0] res_data;
   logic [1:0]    res_rows, res_cols;
   logic          legal, done, active;
`ifdef MM_STREAM_HOST_TIMEOUT_EN
   logic          timeout;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mm_stream_host_if #(.DW(DW), .OW(OW)) bus ();

   mm_stream_host #(.DW(DW), .OW(OW), .TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .rst      (rst),
      .cfg_we   (cfg_we),
      .cfg_sel  (cfg_sel),
      .cfg_row  (cfg_row),
      .cfg_col  (cfg_col),
      .cfg_data (cfg_data),
      .dim1     (dim1),
      .dim2     (dim2),
      .start    (start),
      .bus      (bus),
      .res_addr (res_addr),
      .res_data (res_data),
      .res_rows (res_rows),
      .res_cols (res_cols),
      .legal    (legal),
      .done     (done),
      .active   (active)
`ifdef MM_STREAM_HOST_TIMEOUT_EN
      ,
      .timeout  (timeout)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic sel, input logic [1:0] r, input logic [1:0] c, input logic [7:0] d);
      cfg_we = 1'b1; cfg_sel = sel; cfg_row = r; cfg_col = c; cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   task automatic result(input logic [19:0] d, input logic cr, input logic il);
      bus.valid = 1'b1; bus.out_data = d; bus.change_row = cr; bus.is_legal = il;
      tick();
   endtask

   task automatic rd(input string tag, input logic [3:0] a, input logic [19:0] exp);
      res_addr = a;
      #1;
      chk(tag, 32'(res_data), 32'(exp));
   endtask

   logic [7:0]  exp_d [12];
   logic [11:0] ce_exp;
   logic [11:0] re_exp;
   int          n;

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_sel = 1'b0; cfg_row = '0; cfg_col = '0; cfg_data = '0;
      dim1 = '0; dim2 = '0; start = 1'b0; res_addr = '0;
      bus.busy = 1'b0; bus.valid = 1'b0; bus.out_data = '0; bus.change_row = 1'b0; bus.is_legal = 1'b0;
      #2;
      chk("rst_in_data", 32'(bus.in_data), 32'd0);
      chk("rst_col_end", 32'(bus.col_end), 32'd0);
      chk("rst_row_end", 32'(bus.row_end), 32'd0);
      chk("rst_active",  32'(active),      32'd0);
      chk("rst_done",    32'(done),        32'd0);
      chk("rst_legal",   32'(legal),       32'd0);
      chk("rst_res_rows",32'(res_rows),    32'd0);
      tick(); tick();
      rst = 1'b0;
      tick();

      // Test 1: 2x3 (1..6) times 3x2 (1..6).
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 3; c++) wr(1'b0, 2'(r), 2'(c), 8'(r * 3 + c + 1));
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 2; c++) wr(1'b1, 2'(r), 2'(c), 8'(r * 2 + c + 1));
      exp_d  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
      ce_exp = 12'b1010_1010_0100;
      re_exp = 12'b1000_0010_0000;
      dim1 = 4'b01_10; dim2 = 4'b10_01;
      start = 1'b1; tick(); start = 1'b0;
      chk("t1_active_wait", 32'(active), 32'd1);
      chk("t1_wait_col_end", 32'(bus.col_end), 32'd0);
      tick();
      for (int i = 0; i < 12; i++) begin
         chk($sformatf("t1_in_data[%0d]", i), 32'(bus.in_data), 32'(exp_d[i]));
         chk($sformatf("t1_col_end[%0d]", i), 32'(bus.col_end), 32'(ce_exp[i]));
         chk($sformatf("t1_row_end[%0d]", i), 32'(bus.row_end), 32'(re_exp[i]));
         tick();
      end
      chk("t1_collect_col_end", 32'(bus.col_end), 32'd0);
      chk("t1_collect_row_end", 32'(bus.row_end), 32'd0);
      chk("t1_in_data_hold",    32'(bus.in_data), 32'd6);
      result(20'd22, 1'b0, 1'b1);
      chk("t1_legal_first", 32'(legal), 32'd1);
      chk("t1_done_early0", 32'(done), 32'd0);
      result(20'd28, 1'b1, 1'b1);
      chk("t1_done_early1", 32'(done), 32'd0);
      result(20'd49, 1'b0, 1'b1);
      chk("t1_done_early2", 32'(done), 32'd0);
      result(20'd64, 1'b1, 1'b1);
      bus.valid = 1'b0; bus.change_row = 1'b0;
      chk("t1_done",     32'(done),   32'd1);
      chk("t1_active0",  32'(active), 32'd0);
      tick();
      chk("t1_done_pulse", 32'(done), 32'd0);
      rd("t1_res0", 4'd0, 20'd22);
      rd("t1_res1", 4'd1, 20'd28);
      rd("t1_res4", 4'd4, 20'd49);
      rd("t1_res5", 4'd5, 20'd64);
      chk("t1_res_rows", 32'(res_rows), 32'd1);
      chk("t1_res_cols", 32'(res_cols), 32'd1);
      chk("t1_legal",    32'(legal),    32'd1);

      // Test 2: busy held high for 10 cycles after start.
      bus.busy = 1'b1;
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("t2_busy_active[%0d]", i), 32'(active), 32'd1);
         chk($sformatf("t2_busy_col_end[%0d]", i), 32'(bus.col_end), 32'd0);
         chk($sformatf("t2_busy_in_data[%0d]", i), 32'(bus.in_data), 32'd6);
         tick();
      end
      bus.busy = 1'b0;
      chk("t2_not_yet_sent", 32'(bus.in_data), 32'd6);
      tick();
      chk("t2_first_elem",   32'(bus.in_data), 32'd1);
      chk("t2_active_send",  32'(active), 32'd1);
      repeat (11) tick();
      chk("t2_last_elem",    32'(bus.in_data), 32'd6);
      chk("t2_last_row_end", 32'(bus.row_end), 32'd1);
      tick();
      result(20'd11, 1'b0, 1'b1);
      result(20'd12, 1'b1, 1'b1);
      result(20'd13, 1'b0, 1'b1);
      result(20'd14, 1'b1, 1'b1);
      bus.valid = 1'b0; bus.change_row = 1'b0;
      chk("t2_done", 32'(done), 32'd1);
      tick();
      rd("t2_res0", 4'd0, 20'd11);
      rd("t2_res5", 4'd5, 20'd14);
      chk("t2_res_rows", 32'(res_rows), 32'd1);

      // Test 3: 2x3 times 2x2, engine reports illegal; valid during streaming is ignored.
      dim2 = 4'b01_01;
      start = 1'b1; tick(); start = 1'b0;
      tick();
      chk("t3_first_elem", 32'(bus.in_data), 32'd1);
      bus.valid = 1'b1; bus.out_data = 20'd999; bus.change_row = 1'b1; bus.is_legal = 1'b0;
      repeat (9) tick();
      chk("t3_elem10_row_end", 32'(bus.row_end), 32'd1);
      chk("t3_elem10_data",    32'(bus.in_data), 32'd4);
      chk("t3_send_no_done",   32'(done),   32'd0);
      chk("t3_send_active",    32'(active), 32'd1);
      tick();
      chk("t3_collect_no_done", 32'(done), 32'd0);
      tick();
      bus.valid = 1'b0; bus.change_row = 1'b0;
      chk("t3_done",     32'(done),     32'd1);
      chk("t3_legal",    32'(legal),    32'd0);
      chk("t3_res_rows", 32'(res_rows), 32'd0);
      chk("t3_res_cols", 32'(res_cols), 32'd0);
      tick();
      chk("t3_done_pulse", 32'(done), 32'd0);
      rd("t3_res0_kept", 4'd0, 20'd11);

      // Test 4: 1x1 times 1x1, operands -128.
      wr(1'b0, 2'd0, 2'd0, 8'h80);
      wr(1'b1, 2'd0, 2'd0, 8'h80);
      dim1 = 4'd0; dim2 = 4'd0;
      start = 1'b1; tick(); start = 1'b0;
      tick();
      chk("t4_e1_data",    32'(bus.in_data), 32'h80);
      chk("t4_e1_col_end", 32'(bus.col_end), 32'd1);
      chk("t4_e1_row_end", 32'(bus.row_end), 32'd1);
      tick();
      chk("t4_e2_data",    32'(bus.in_data), 32'h80);
      chk("t4_e2_col_end", 32'(bus.col_end), 32'd1);
      chk("t4_e2_row_end", 32'(bus.row_end), 32'd1);
      tick();
      chk("t4_collect_col_end", 32'(bus.col_end), 32'd0);
      result(20'd16384, 1'b1, 1'b1);
      bus.valid = 1'b0; bus.change_row = 1'b0;
      chk("t4_done",  32'(done),  32'd1);
      chk("t4_legal", 32'(legal), 32'd1);
      rd("t4_res0", 4'd0, 20'd16384);
      chk("t4_res_rows", 32'(res_rows), 32'd0);
      chk("t4_res_cols", 32'(res_cols), 32'd0);
      tick();

      // Test 5: reset during SEND2, cfg write while active ignored, then a clean run.
      start = 1'b1; tick(); start = 1'b0;
      tick();
      cfg_we = 1'b1; cfg_sel = 1'b0; cfg_row = 2'd0; cfg_col = 2'd0; cfg_data = 8'd7;
      tick();
      cfg_we = 1'b0;
      chk("t5_send2_row_end", 32'(bus.row_end), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_in_data", 32'(bus.in_data), 32'd0);
      chk("t5_rst_col_end", 32'(bus.col_end), 32'd0);
      chk("t5_rst_row_end", 32'(bus.row_end), 32'd0);
      chk("t5_rst_active",  32'(active),      32'd0);
      chk("t5_rst_legal",   32'(legal),       32'd0);
      chk("t5_rst_done",    32'(done),        32'd0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("t5_no_done[%0d]", i), 32'(done), 32'd0);
         tick();
      end
      start = 1'b1; tick(); start = 1'b0;
      tick();
      chk("t5_clean_data",    32'(bus.in_data), 32'h80);
      chk("t5_clean_row_end", 32'(bus.row_end), 32'd1);
      tick(); tick();
      result(20'd16384, 1'b1, 1'b1);
      bus.valid = 1'b0; bus.change_row = 1'b0;
      chk("t5_done",  32'(done),  32'd1);
      chk("t5_legal", 32'(legal), 32'd1);
      tick();

`ifdef MM_STREAM_HOST_TIMEOUT_EN
      // Test 6: no result ever arrives.
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick();
      n = 0;
      while (!done && n < 200) begin
         tick();
         n++;
      end
      chk("t6_timeout_cycles", 32'(n), 32'(TIMEOUT));
      chk("t6_timeout", 32'(timeout), 32'd1);
      chk("t6_legal",   32'(legal),   32'd0);
      tick();
      chk("t6_done_pulse",    32'(done),    32'd0);
      chk("t6_timeout_holds", 32'(timeout), 32'd1);
      start = 1'b1; tick(); start = 1'b0;
      chk("t6_timeout_clear", 32'(timeout), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
